// File: rtl/aluvol2_pkg.sv
// ============================================================================
//  Package  : aluvol2_pkg
//  Purpose  : Shared width, opcode and sweep-state types for the aluvol2 ALU.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package aluvol2_pkg;

    localparam int N       = 8;
    localparam int NUM_OPS = 8;

    typedef logic [2:0] opcode_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEEK  = 3'd1,
        DRIVE = 3'd2,
        OUT   = 3'd3,
        DONE  = 3'd4
    } sweep_state_t;

endpackage : aluvol2_pkg

`default_nettype wire

// File: rtl/alu_sweep_driver.sv
// ============================================================================
//  Module   : alu_sweep_driver
//  Purpose  : Runs every opcode enabled in a mask through an external ALU and
//             streams the sampled results out over valid/ready.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module alu_sweep_driver
    import aluvol2_pkg::*;
#(
    parameter int N      = aluvol2_pkg::N,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [N-1:0] start_a,
    input  logic [N-1:0] start_b,
    input  logic [7:0]   op_mask,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [2:0]   alu_opcode,
    input  logic [N-1:0] alu_y,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [2:0]   res_opcode,
    output logic [N-1:0] res_y,
    output logic         res_last,
    output logic         busy,
    output logic         done
);

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

    sweep_state_t state_q, state_d;
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;
    logic [7:0]   mask_q, mask_d;
    opcode_t      idx_q, idx_d;
    logic [3:0]   cnt_q, cnt_d;
    opcode_t      op_q, op_d;
    logic [N-1:0] y_q, y_d;
    opcode_t      resop_q, resop_d;
    logic         last_q, last_d;

    // True when any opcode above i is still enabled.
    function automatic logic higher_set(input logic [7:0] m, input opcode_t i);
        logic r;
        r = 1'b0;
        for (int k = 0; k < NUM_OPS; k++) begin
            if ((k > int'(i)) && m[k]) begin
                r = 1'b1;
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            mask_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            y_q     <= '0;
            resop_q <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mask_q  <= mask_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            y_q     <= y_d;
            resop_q <= resop_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        mask_d      = mask_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        y_d         = y_q;
        resop_d     = resop_q;
        last_d      = last_q;
        start_ready = rst_n && (state_q == IDLE);

        case (state_q)
            IDLE: begin
                if (start_valid && start_ready) begin
                    a_d     = start_a;
                    b_d     = start_b;
                    mask_d  = op_mask;
                    idx_d   = '0;
                    state_d = SEEK;
                end
            end
            SEEK: begin
                if (mask_q[idx_q]) begin
                    cnt_d   = CNT_LOAD;
                    op_d    = idx_q;
                    state_d = DRIVE;
                end else if (idx_q == 3'd7) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            DRIVE: begin
                // Opcode has been held SETTLE cycles once the counter hits zero.
                if (cnt_q == 4'd0) begin
                    y_d     = alu_y;
                    resop_d = idx_q;
                    last_d  = !higher_set(mask_q, idx_q);
                    state_d = OUT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            OUT: begin
                if (res_ready) begin
                    if (last_q) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = SEEK;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_opcode = op_q;
    assign res_y      = y_q;
    assign res_opcode = resop_q;
    assign res_last   = last_q;
    assign res_valid  = (state_q == OUT);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);

endmodule : alu_sweep_driver

`default_nettype wire

// File: tb/tb_alu_sweep_driver.sv
// ============================================================================
//  Module   : tb_alu_sweep_driver
//  Purpose  : Scoreboard bench for alu_sweep_driver with an XOR ALU stub.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_sweep_driver;
    import aluvol2_pkg::*;

    typedef struct {
        logic [2:0] op;
        logic [7:0] y;
        logic       last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_valid = 1'b0;
    logic       start_ready;
    logic [7:0] start_a = '0;
    logic [7:0] start_b = '0;
    logic [7:0] op_mask = '0;
    logic [7:0] alu_a, alu_b, alu_y;
    logic [2:0] alu_opcode;
    logic       res_valid;
    logic       res_ready = 1'b1;
    logic [2:0] res_opcode;
    logic [7:0] res_y;
    logic       res_last, busy, done;

    logic       sv3 = 1'b0;
    logic       sr3;
    logic [7:0] a3_o, b3_o, y3;
    logic [2:0] op3, resop3;
    logic       rv3, last3, busy3, done3;
    logic [7:0] resy3;

    exp_t sb[$];
    int   cyc = 0;
    int   acc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign alu_y = alu_a ^ alu_b ^ {5'b0, alu_opcode};
    assign y3    = a3_o ^ b3_o ^ {5'b0, op3};

    alu_sweep_driver #(.N(8), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
        .start_a(start_a), .start_b(start_b), .op_mask(op_mask),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_y(alu_y),
        .res_valid(res_valid), .res_ready(res_ready), .res_opcode(res_opcode),
        .res_y(res_y), .res_last(res_last), .busy(busy), .done(done)
    );

    alu_sweep_driver #(.N(8), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv3), .start_ready(sr3),
        .start_a(8'd73), .start_b(8'd42), .op_mask(8'h03),
        .alu_a(a3_o), .alu_b(b3_o), .alu_opcode(op3), .alu_y(y3),
        .res_valid(rv3), .res_ready(1'b1), .res_opcode(resop3),
        .res_y(resy3), .res_last(last3), .busy(busy3), .done(done3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [2:0] op, input logic [7:0] y, input logic last);
        exp_t e;
        e.op = op; e.y = y; e.last = last;
        sb.push_back(e);
    endtask

    // Monitor: compares every presented result; pops on handshake.
    always @(negedge clk) begin
        if (rst_n && res_valid) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: got op %0d y %0d expected none", res_opcode, res_y);
            end else begin
                chk("res_y", 32'(res_y), 32'(sb[0].y));
                chk("res_opcode", 32'(res_opcode), 32'(sb[0].op));
                chk("res_last", 32'(res_last), 32'(sb[0].last));
                if (res_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m);
        @(posedge clk); #1;
        start_a = a; start_b = b; op_mask = m; start_valid = 1'b1;
        @(negedge clk);
        chk("start_ready", 32'(start_ready), 32'd1);
        @(posedge clk); #1;
        start_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_done(input int exp_cycle, input int exp_busy);
        int busy_n;
        bit seen;
        busy_n = 0;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: got no done expected done at cycle %0d", exp_cycle);
        end else begin
            chk("done_cycle", 32'(cyc - acc + 1), 32'(exp_cycle));
            if (exp_busy >= 0) chk("busy_cycles", 32'(busy_n), 32'(exp_busy));
            @(negedge clk);
            chk("done_pulse_width", 32'(done), 32'd0);
            chk("ready_after_done", 32'(start_ready), 32'd1);
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        bit got;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_start_ready", 32'(start_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_opcode", 32'(alu_opcode), 32'd0);
        chk("rst_res_y", 32'(res_y), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_start_ready", 32'(start_ready), 32'd1);

        // Full sweep, with an ignored command mid-sweep.
        issue(8'd73, 8'd42, 8'hFF);
        push(3'd0, 8'd99, 1'b0);  push(3'd1, 8'd98, 1'b0);
        push(3'd2, 8'd97, 1'b0);  push(3'd3, 8'd96, 1'b0);
        push(3'd4, 8'd103, 1'b0); push(3'd5, 8'd102, 1'b0);
        push(3'd6, 8'd101, 1'b0); push(3'd7, 8'd100, 1'b1);
        repeat (4) @(posedge clk); #1;
        start_a = 8'hFF; start_b = 8'h00; op_mask = 8'h00; start_valid = 1'b1;
        @(negedge clk);
        chk("busy_start_ready", 32'(start_ready), 32'd0);
        @(posedge clk); #1;
        start_valid = 1'b0;
        @(negedge clk);
        chk("busy_alu_a_held", 32'(alu_a), 32'd73);
        wait_done(25, -1);

        // Sparse mask.
        issue(8'd73, 8'd42, 8'hA4);
        push(3'd2, 8'd97, 1'b0); push(3'd5, 8'd102, 1'b0); push(3'd7, 8'd100, 1'b1);
        wait_done(15, 15);

        // Empty mask; the opcode from the previous sweep is held.
        issue(8'd73, 8'd42, 8'h00);
        wait_done(9, 9);
        chk("opcode_held_idle", 32'(alu_opcode), 32'd7);

        // Backpressure on the first result.
        @(posedge clk); #1;
        res_ready = 1'b0;
        issue(8'd73, 8'd42, 8'h03);
        push(3'd0, 8'd99, 1'b0); push(3'd1, 8'd98, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (res_valid) got = 1'b1;
        end
        chk("bp_valid_cycle", 32'(cyc - acc + 1), 32'd3);
        repeat (5) @(posedge clk); #1;
        res_ready = 1'b1;
        wait_done(12, -1);

        // Reset in cycle 7 of a full sweep.
        issue(8'd73, 8'd42, 8'hFF);
        push(3'd0, 8'd99, 1'b0); push(3'd1, 8'd98, 1'b0);
        repeat (6) @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_alu_a", 32'(alu_a), 32'd0);
        chk("mid_rst_alu_b", 32'(alu_b), 32'd0);
        chk("mid_rst_alu_opcode", 32'(alu_opcode), 32'd0);
        chk("mid_rst_res_y", 32'(res_y), 32'd0);
        chk("mid_rst_res_opcode", 32'(res_opcode), 32'd0);
        chk("mid_rst_res_last", 32'(res_last), 32'd0);
        chk("mid_rst_start_ready", 32'(start_ready), 32'd0);
        chk("mid_rst_scoreboard", 32'(sb.size()), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rst_no_done", 32'(done), 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(8'd1, 8'd1, 8'h01);
        push(3'd0, 8'd0, 1'b1);
        wait_done(4, 4);

        // SETTLE = 3 instance: five cycles per enabled opcode.
        @(posedge clk); #1;
        sv3 = 1'b1;
        @(negedge clk);
        chk("s3_start_ready", 32'(sr3), 32'd1);
        @(posedge clk); #1;
        sv3 = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            chk("s3_res_valid", 32'(rv3), 32'((c == 5) || (c == 10)));
            chk("s3_done", 32'(done3), 32'(c == 11));
            if (c >= 2 && c <= 4) chk("s3_opcode0_held", 32'(op3), 32'd0);
            if (c >= 7 && c <= 9) chk("s3_opcode1_held", 32'(op3), 32'd1);
            if (c == 5) chk("s3_res_y0", 32'(resy3), 32'd99);
            if (c == 10) begin
                chk("s3_res_y1", 32'(resy3), 32'd98);
                chk("s3_res_last", 32'(last3), 32'd1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_alu_sweep_driver

`default_nettype wire

// File: doc/alu_sweep_driver.md
# alu_sweep_driver

- Sequential initiator for the `aluvol2` combinational ALU.
- Accepts one operand pair plus an 8-bit opcode mask over a valid/ready command port.
- For each enabled opcode in ascending order it:
  - drives the ALU,
  - waits a programmable settle time,
  - samples `Y`,
  - emits the result on a valid/ready result stream.
- Sits between a command source and the ALU. The ALU is instantiated beside it in the system wrapper, not inside it.

## Interface
Parameters:
- `N`, default `aluvol2_pkg::N`: operand/result width.
- `SETTLE`, default 1: cycles the opcode is held before `alu_y` is sampled; legal range 1..15.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start_valid`  in  1  command valid.
- `start_ready`  out  1  command ready.
- `start_a`  in  N  operand A.
- `start_b`  in  N  operand B.
- `op_mask`  in  8  bit i set means run opcode i.
- `alu_a`  out  N  to ALU `A`.
- `alu_b`  out  N  to ALU `B`.
- `alu_opcode`  out  3  to ALU `opcode`.
- `alu_y`  in  N  from ALU `Y` (combinational).
- `res_valid`  out  1  result valid.
- `res_ready`  in  1  result ready.
- `res_opcode`  out  3  opcode of this result.
- `res_y`  out  N  captured ALU result.
- `res_last`  out  1  final result of this command.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a command completes.

## Operation
- **IDLE**
  - `start_ready` = 1 (forced 0 while `rst_n` = 0).
  - On `start_valid && start_ready`: latch `start_a`, `start_b`, `op_mask`; set `idx` = 0; go to SEEK.
- **SEEK**
  - If `mask[idx]` = 1: load the settle counter with `SETTLE-1`; go to DRIVE.
  - Else if `idx` = 7: go to DONE.
  - Else: `idx++` and stay in SEEK.
  - Each skipped opcode costs one cycle.
- **DRIVE**
  - `alu_opcode` = `idx`; count down.
  - In the cycle the counter reaches 0, register `res_y` ← `alu_y` and `res_opcode` ← `idx`.
  - Register `res_last` = 1 when no mask bit above `idx` is set.
  - Go to OUT.
- **OUT**
  - `res_valid` = 1; `res_y`, `res_opcode` and `res_last` are stable until `res_ready` is seen.
  - On handshake: if `res_last`, go to DONE; else `idx++` and go to SEEK.
- **DONE**
  - `done` = 1 for exactly one cycle; go to IDLE.
- **Operand holding**
  - `alu_a`/`alu_b` hold the latched operands from accept until the next accept.
  - `alu_opcode` holds its last driven value in IDLE.
- **Empty mask**
  - `op_mask` = 0: SEEK walks idx 0..7, no results are emitted, then DONE pulses.
- **Busy and backpressure**
  - `start_valid` while busy is ignored, with no latching.
  - `res_ready` may be high before `res_valid`. Backpressure stalls only OUT.
- **Width rule**
  - `res_y` is exactly N bits, captured unmodified; no extension or truncation.

## Timing
- **Reset values** (registered, applied on a `clk` edge with `rst_n` = 0):
  - State = IDLE.
  - `alu_a`, `alu_b`, `alu_opcode`, `res_y`, `res_opcode` = 0.
  - `res_valid`, `res_last`, `busy`, `done` = 0.
- **Reset mid-operation:** at the next edge return to IDLE and drop any pending result. `res_valid` falls and no `done` pulse is produced.
- **Latency** (`SETTLE` = 1, `res_ready` held high, accept at edge 0):
  - SEEK in cycle 1, DRIVE in cycle 2, `res_valid` in cycle 3.
  - Three cycles per enabled opcode, plus one per skipped opcode.
  - Full mask: last result in cycle 24, `done` in cycle 25, `start_ready` again in cycle 26.
- **Settle time:** `alu_opcode` is stable for `SETTLE` full cycles before sampling. `alu_a`/`alu_b` are stable for at least `SETTLE`+1 cycles.

## Structure
- Extend `aluvol2_pkg` with:
  - `opcode_t` (logic [2:0])
  - `NUM_OPS` = 8
  - `sweep_state_t` enum {IDLE, SEEK, DRIVE, OUT, DONE}
- No sub-module. The next-enabled-bit check for `res_last` is a local function.
- The system wrapper `alu_sweep_top` instantiates `alu_sweep_driver` plus `aluvol2`.

## Test plan
The bench uses an ALU stub with `alu_y` = `alu_a ^ alu_b ^ opcode` and `N` = 8. With A = 73, B = 42, the base value is 99.
- **Full sweep:** mask 8'hFF, `SETTLE` = 1, `res_ready` = 1 → 8 results, opcodes 0..7, `res_y` = 99, 98, 97, 96, 103, 102, 101, 100. `res_last` only on opcode 7; `done` in cycle 25.
- **Sparse mask:** mask 8'b1010_0100 → results for opcode 2 (97), 5 (102), 7 (100). Each skipped opcode costs one cycle; `res_last` only on 7.
- **Empty mask:** mask 0 → no `res_valid`; `done` pulses in cycle 9; `busy` is high for cycles 1..9.
- **Backpressure:** mask 8'h03, `res_ready` held low 5 cycles on the first result → `res_valid`, `res_y` = 99 and `res_opcode` = 0 stable throughout; second result 98 follows normally.
- **Reset mid-sweep:** `rst_n` low in cycle 7 of a full sweep → all outputs reach reset values at the next edge. A new command (A = 1, B = 1, mask 8'h01) then yields `res_y` = 0.
- **Busy/settle:** `start_valid` pulsed during a sweep is ignored. With `SETTLE` = 3, each enabled opcode takes 5 cycles and `alu_opcode` is stable 3 cycles before capture.
